// File: rtl/rho_rotate.sv
// Keccak rho stage: captures 64 slices of 25 cells, then streams them back with every lane rotated by its rho offset.
// Define RHO_OUT_REG_EN to register data_out/out_valid/done (adds one cycle of output latency).
module rho_rotate #(
    parameter int NUM_CELLS  = 25,
    parameter int NUM_SLICES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CELLS-1:0] data_in,
    output logic                 loading,
    output logic                 out_valid,
    output logic [NUM_CELLS-1:0] data_out,
    output logic                 done
);

    localparam int CNT_W = $clog2(NUM_SLICES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SLICES - 1);

    // Offsets indexed by cell i = x + 5*y
    localparam logic [5:0] RHO [25] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [NUM_CELLS-1:0] state_buf_reg [NUM_SLICES];
    logic [NUM_CELLS-1:0] slice_mux;
    logic                 emit_active;
    logic [NUM_CELLS-1:0] data_out_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            LOAD: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = EMIT;
                    cnt_next   = '0;
                end
            end
            EMIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slice buffer has no reset; its contents only matter within a run
    always_ff @(posedge clk) begin
        if (state_reg == LOAD) begin
            state_buf_reg[cnt_reg] <= data_in;
        end
    end

    // Each cell picks its bit from the slice that lies r[x][y] behind the current output slice
    generate
        for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            logic [CNT_W-1:0] src_slice;
            assign src_slice     = cnt_reg - CNT_W'(RHO[gi]);
            assign slice_mux[gi] = state_buf_reg[src_slice][gi];
        end
    endgenerate

    assign loading       = (state_reg == LOAD);
    assign emit_active   = (state_reg == EMIT);
    assign data_out_next = emit_active ? slice_mux : '0;

`ifdef RHO_OUT_REG_EN
    logic                 out_valid_reg;
    logic                 done_reg;
    logic [NUM_CELLS-1:0] data_out_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            data_out_reg  <= '0;
        end else begin
            out_valid_reg <= emit_active;
            done_reg      <= (state_reg == DONE);
            data_out_reg  <= data_out_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign done      = done_reg;
    assign data_out  = data_out_reg;
`else
    assign out_valid = emit_active;
    assign done      = (state_reg == DONE);
    assign data_out  = data_out_next;
`endif

endmodule

// File: tb/tb_rho_rotate.sv
// Self-checking bench for rho_rotate: directed runs with random states compared against a lane-rotation model.
module tb_rho_rotate;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [24:0] data_in;
    logic        loading;
    logic        out_valid;
    logic [24:0] data_out;
    logic        done;

    int checks = 0;
    int errors = 0;

    // rho offsets listed per y, x = 0..4
    int rho_tab [25] = '{0, 1, 62, 28, 27,
                         36, 44, 6, 55, 20,
                         3, 10, 43, 25, 39,
                         41, 45, 15, 21, 8,
                         18, 2, 61, 56, 14};

    logic [24:0] in_state [64];
    logic [24:0] exp_out  [64];
    logic [24:0] got_out  [64];

    rho_rotate dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .loading  (loading),
        .out_valid(out_valid),
        .data_out (data_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model: gather each lane as a 64-bit word, rotate it left by its offset, scatter back into slices
    task automatic build_expected();
        logic [63:0] lane;
        logic [63:0] rot;
        int r;
        for (int z = 0; z < 64; z++) exp_out[z] = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                for (int z = 0; z < 64; z++) lane[z] = in_state[z][x + 5*y];
                r = rho_tab[x + 5*y];
                rot = (r == 0) ? lane : ((lane << r) | (lane >> (64 - r)));
                for (int z = 0; z < 64; z++) exp_out[z][x + 5*y] = rot[z];
            end
        end
    endtask

    // Called at #1 after a rising edge with the DUT idle; abort_at >= 0 applies reset in that emit cycle
    task automatic run(input string name, input bit stray_start, input int abort_at);
        int load_cnt;
        build_expected();
        start   = 1'b1;
        data_in = 25'($urandom);
        step();
        start    = 1'b0;
        load_cnt = 0;
        for (int z = 0; z < 64; z++) begin
            data_in = in_state[z];
            start   = stray_start && (z == 10);
            if (loading === 1'b1) load_cnt++;
            if (z == 0 || z == 63) chk({name, "_noval_in_load"}, 64'(out_valid), 64'd0);
            step();
        end
        start   = 1'b0;
        data_in = 25'($urandom);
        chk({name, "_loading_cycles"}, 64'(load_cnt), 64'd64);
        chk({name, "_loading_off"}, 64'(loading), 64'd0);
`ifdef RHO_OUT_REG_EN
        chk({name, "_noval_pre"}, 64'(out_valid), 64'd0);
        step();
`endif
        for (int z = 0; z < 64; z++) begin
            if (z == abort_at) begin
                rst = 1'b1;
                #1;
                chk({name, "_abort_valid"}, 64'(out_valid), 64'd0);
                chk({name, "_abort_data"}, 64'(data_out), 64'd0);
                chk({name, "_abort_done"}, 64'(done), 64'd0);
                step();
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    chk({name, "_abort_nodone"}, 64'(done), 64'd0);
                    step();
                end
                return;
            end
            chk({name, "_valid"}, 64'(out_valid), 64'd1);
            chk({name, "_slice"}, 64'(data_out), 64'(exp_out[z]));
            got_out[z] = data_out;
            start = stray_start && (z == 7);
            chk({name, "_nodone_emit"}, 64'(done), 64'd0);
            step();
        end
        start = 1'b0;
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_valid_off"}, 64'(out_valid), 64'd0);
        chk({name, "_data_zero"}, 64'(data_out), 64'd0);
        step();
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
        chk({name, "_idle_loading"}, 64'(loading), 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;

        // Reset with random inputs
        for (int k = 0; k < 5; k++) begin
            start   = 1'($urandom);
            data_in = 25'($urandom);
            step();
            chk("rst_loading", 64'(loading), 64'd0);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_data", 64'(data_out), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
        end
        rst     = 1'b0;
        start   = 1'b0;
        data_in = 25'($urandom);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("idle_quiet", {61'd0, loading, out_valid, done}, 64'd0);
            chk("idle_data", 64'(data_out), 64'd0);
        end

        // Single-bit walk: cell x=1,y=0 in slice 0 lands in slice 1
        for (int z = 0; z < 64; z++) in_state[z] = '0;
        in_state[0] = 25'h0000002;
        run("walk", 1'b0, -1);
        chk("walk_slice1", 64'(got_out[1]), 64'h2);
        chk("walk_slice0", 64'(got_out[0]), 64'h0);

        // Wrap-around: cell x=2,y=0 (r=62) in slice 5 lands in slice 3
        for (int z = 0; z < 64; z++) in_state[z] = '0;
        in_state[5] = 25'h0000004;
        run("wrap", 1'b0, -1);
        chk("wrap_slice3", 64'(got_out[3]), 64'h4);
        chk("wrap_slice5", 64'(got_out[5]), 64'h0);

        // Full random state with stray starts, then back-to-back run
        for (int z = 0; z < 64; z++) in_state[z] = 25'($urandom);
        run("full", 1'b1, -1);
        for (int z = 0; z < 64; z++) in_state[z] = 25'($urandom);
        run("b2b", 1'b0, -1);

        // Reset in emit cycle 20, then a normal run
        for (int z = 0; z < 64; z++) in_state[z] = 25'($urandom);
        run("abort", 1'b0, 20);
        for (int z = 0; z < 64; z++) in_state[z] = 25'($urandom);
        run("after_abort", 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
